// File: rtl/program_loader_pkg.sv
// Shared state encoding and default sizing for the program loader.
package program_loader_pkg;
  localparam int LD_ADDR_W = 5;
  localparam int LD_DEPTH  = 2 ** LD_ADDR_W;
  localparam int LD_CYC_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    FLUSH,
    RUN,
    DONE,
    ERR
  } ld_state_t;
endpackage

// File: rtl/ld_cycle_counter.sv
// Loadable down-counter that flags the final cycle of a run budget.
// A zero budget is promoted to one so the core always runs.
module ld_cycle_counter
  import program_loader_pkg::*;
#(
  parameter int W = LD_CYC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         last
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (value == '0) ? W'(1) : value;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));
endmodule

// File: rtl/program_loader.sv
// Loads a program into the core's instruction memory, runs it, captures
// the result. PROGRAM_LOADER_CKSUM_EN adds a trailing XOR checksum word.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W,
  parameter int DEPTH  = LD_DEPTH,
  parameter int DATA_W = 32,
  parameter int CYC_W  = LD_CYC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              ins_wr,
  output logic [ADDR_W-1:0] ins_addr,
  output logic [DATA_W-1:0] ins_data,
  output logic              core_reset,
  input  logic [DATA_W-1:0] result_in,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  ld_state_t        state;
  logic [ADDR_W:0]  len;
  logic [ADDR_W:0]  idx;
  logic [CYC_W-1:0] cyc;
  logic             last;
  logic             bad_len;
  logic             take;

`ifdef PROGRAM_LOADER_CKSUM_EN
  logic [DATA_W-1:0] cksum;
  logic [DATA_W-1:0] ck_word;
`endif

  assign bad_len = (prog_len == '0) || (prog_len > MAX_LEN);
  assign take    = s_valid & s_ready;

  ld_cycle_counter #(.W(CYC_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (reset),
    .load  (state == FLUSH),
    .en    (state == RUN),
    .value (cyc),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      s_ready    <= 1'b0;
      ins_wr     <= 1'b0;
      ins_addr   <= '0;
      ins_data   <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      idx        <= '0;
      cyc        <= '0;
`ifdef PROGRAM_LOADER_CKSUM_EN
      cksum      <= '0;
      ck_word    <= '0;
`endif
    end else begin
      ins_wr <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        core_reset <= 1'b1;
        s_ready    <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
        err        <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE, ERR: if (start) begin
            done <= 1'b0;
            if (bad_len) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state   <= LOAD;
              err     <= 1'b0;
              len     <= prog_len;
              cyc     <= run_cycles;
              idx     <= '0;
              s_ready <= 1'b1;
              busy    <= 1'b1;
`ifdef PROGRAM_LOADER_CKSUM_EN
              cksum   <= '0;
`endif
            end
          end
          LOAD: if (take) begin
`ifdef PROGRAM_LOADER_CKSUM_EN
            // The word after the program is the checksum, never stored.
            if (idx == len) begin
              ck_word <= s_data;
              s_ready <= 1'b0;
              state   <= CHECK;
            end else begin
              ins_wr   <= 1'b1;
              ins_addr <= idx[ADDR_W-1:0];
              ins_data <= s_data;
              cksum    <= cksum ^ s_data;
              idx      <= idx + 1'b1;
            end
`else
            ins_wr   <= 1'b1;
            ins_addr <= idx[ADDR_W-1:0];
            ins_data <= s_data;
            idx      <= idx + 1'b1;
            if (idx == len - 1'b1) begin
              s_ready <= 1'b0;
              state   <= FLUSH;
            end
`endif
          end
`ifdef PROGRAM_LOADER_CKSUM_EN
          CHECK: begin
            if (ck_word == cksum) begin
              state <= FLUSH;
            end else begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
`endif
          FLUSH: begin
            state      <= RUN;
            core_reset <= 1'b0;
          end
          RUN: if (last) begin
            state      <= DONE;
            result     <= result_in;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Table-driven and randomized bench for program_loader.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset, start, abort, s_valid, s_ready;
  logic        ins_wr, core_reset, busy, done, err;
  logic [5:0]  prog_len;
  logic [15:0] run_cycles;
  logic [31:0] s_data, ins_data, result_in, result;
  logic [4:0]  ins_addr;

  int checks = 0;
  int errors = 0;

  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  int          run_cnt = 0;
  logic [31:0] last_res = '0;
  logic [31:0] words[$];
`ifdef PROGRAM_LOADER_CKSUM_EN
  logic [31:0] ck_delta = '0;
`endif

  typedef struct {
    int len;
    int cyc;
    int mode;
    bit exp_err;
  } vec_t;

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .ins_wr     (ins_wr),
    .ins_addr   (ins_addr),
    .ins_data   (ins_data),
    .core_reset (core_reset),
    .result_in  (result_in),
    .result     (result),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Instruction-memory port and core-release observer.
  always @(posedge clk) begin
    if (ins_wr) begin
      wa.push_back(ins_addr);
      wd.push_back(ins_data);
    end
    if (!core_reset) begin
      run_cnt++;
      last_res = result_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    result_in = $urandom();
  endtask

  task automatic run_txn(input int len, input int cyc, input int mode,
                         input bit exp_err);
    int base, rbase, n, i, g, exp_run;
    logic [31:0] stream[$];
    logic [31:0] x;
    logic v, hs;
    base    = wa.size();
    rbase   = run_cnt;
    exp_run = (cyc == 0) ? 1 : cyc;
    prog_len   = 6'(len);
    run_cycles = 16'(cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    if (exp_err) begin
      chk("err_flag", err, 1);
      chk("err_core_reset", core_reset, 1);
      chk("err_ready", s_ready, 0);
      repeat (4) step();
      chk("err_no_write", wa.size() - base, 0);
      chk("err_no_run", run_cnt - rbase, 0);
      chk("err_hold", err, 1);
      return;
    end
    chk("start_ready", s_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    x = '0;
    for (int k = 0; k < len; k++) begin
      stream.push_back(words[k]);
      x ^= words[k];
    end
`ifdef PROGRAM_LOADER_CKSUM_EN
    stream.push_back(x ^ ck_delta);
`endif
    n = stream.size();
    i = 0;
    g = 0;
    while (i < n && g < 8 * n + 40) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (g % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = stream[i];
      hs      = v & s_ready;
      step();
      g++;
      if (hs) i++;
    end
    s_valid = 1'b0;
    chk("feed_count", i, n);
`ifdef PROGRAM_LOADER_CKSUM_EN
    if (ck_delta != '0) begin
      step();
      chk("ck_err", err, 1);
      chk("ck_core_reset", core_reset, 1);
      repeat (3) step();
      chk("ck_no_run", run_cnt - rbase, 0);
      return;
    end
    step();
`else
    chk("flush_wr", ins_wr, 1);
`endif
    chk("flush_ready", s_ready, 0);
    chk("flush_core_reset", core_reset, 1);
    step();
    chk("run_entry", core_reset, 0);
    g = 0;
    while (!done && g < exp_run + 8) begin
      step();
      g++;
    end
    chk("done", done, 1);
    chk("busy_after", busy, 0);
    chk("core_reset_after", core_reset, 1);
    chk("run_len", run_cnt - rbase, exp_run);
    chk("result", result, last_res);
    chk("wr_count", wa.size() - base, len);
    for (int k = 0; k < len && base + k < wa.size(); k++) begin
      chk("wr_addr", wa[base+k], k);
      chk("wr_data", wd[base+k], words[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    logic [31:0] saved;
    int          base, rb, g;
    reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    s_data = '0; prog_len = '0; run_cycles = '0; result_in = '0;
    tbl[0] = '{3, 10, 0, 1'b0};
    tbl[1] = '{3, 10, 1, 1'b0};
    tbl[2] = '{0, 5, 0, 1'b1};
    tbl[3] = '{33, 5, 0, 1'b1};
    tbl[4] = '{32, 0, 0, 1'b0};
    tbl[5] = '{1, 1, 1, 1'b0};
    tbl[6] = '{4, 7, 2, 1'b0};
    tbl[7] = '{2, 3, 0, 1'b0};

    #1 reset = 1'b0;
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", s_ready, 0);
    chk("rst_wr", ins_wr, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    step();
    step();
    reset = 1'b1;
    step();

    for (int t = 0; t < 8; t++) begin
      words.delete();
      if (t == 0) words = '{32'hE3A00005, 32'hE2800003, 32'hE0800000};
      else for (int k = 0; k < tbl[t].len; k++) words.push_back($urandom());
      run_txn(tbl[t].len, tbl[t].cyc, tbl[t].mode, tbl[t].exp_err);
    end

    // Abort while the third of four words is offered.
    saved = result;
    base  = wa.size();
    prog_len = 6'd4; run_cycles = 16'd5;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = $urandom(); step();
    end
    s_data = $urandom(); abort = 1'b1; step();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_load_core_reset", core_reset, 1);
    chk("abort_load_ready", s_ready, 0);
    chk("abort_load_busy", busy, 0);
    chk("abort_load_result", result, saved);
    step(); step();
    chk("abort_load_writes", wa.size() - base, 2);
    words.delete();
    for (int k = 0; k < 4; k++) words.push_back($urandom());
    run_txn(4, 6, 0, 1'b0);

    // Abort after four RUN cycles of a twenty-cycle budget.
    saved = result;
    words.delete();
    for (int k = 0; k < 2; k++) words.push_back($urandom());
    prog_len = 6'd2; run_cycles = 16'd20;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = words[k]; step();
    end
`ifdef PROGRAM_LOADER_CKSUM_EN
    s_data = words[0] ^ words[1]; step();
`endif
    s_valid = 1'b0;
    g = 0;
    while (core_reset && g < 10) begin step(); g++; end
    chk("run_reached", core_reset, 0);
    rb = run_cnt;
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_run_core_reset", core_reset, 1);
    chk("abort_run_result", result, saved);
    chk("abort_run_busy", busy, 0);
    chk("abort_run_done", done, 0);
    repeat (4) step();
    chk("abort_run_len", run_cnt - rb, 4);

    for (int r = 0; r < 6; r++) begin
      int len, cyc;
      len = $urandom_range(1, 32);
      cyc = $urandom_range(0, 12);
      words.delete();
      for (int k = 0; k < len; k++) words.push_back($urandom());
      run_txn(len, cyc, 2, 1'b0);
    end

`ifdef PROGRAM_LOADER_CKSUM_EN
    words = '{32'h1, 32'h2};
    ck_delta = '0;
    run_txn(2, 4, 0, 1'b0);
    ck_delta = 32'h7;
    run_txn(2, 4, 0, 1'b0);
    ck_delta = '0;
`endif

    // Asynchronous reset in the middle of LOAD.
    prog_len = 6'd4; run_cycles = 16'd3;
    start = 1'b1; step(); start = 1'b0;
    s_valid = 1'b1; s_data = 32'hA5A50001; step();
    s_data = 32'h12345678;
    #2 reset = 1'b0;
    #1;
    chk("areset_core_reset", core_reset, 1);
    chk("areset_ready", s_ready, 0);
    chk("areset_wr", ins_wr, 0);
    chk("areset_addr", ins_addr, 0);
    chk("areset_data", ins_data, 0);
    chk("areset_result", result, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_err", err, 0);
    s_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    words.delete();
    for (int k = 0; k < 3; k++) words.push_back($urandom());
    run_txn(3, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Host-side controller that sequences the single-cycle ARM core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into the core's instruction memory through its write port, holding the core in reset meanwhile. It then releases the core for a programmed number of cycles, captures the core's result word and parks the core back in reset. It sits between the host interface (UART or testbench) and the core's `write_ins`/`ins_address`/`ins`/`reset`/`resultado_out` pins.

## Interface
Parameters:
- `ADDR_W`, 5: instruction memory address width.
- `DEPTH`, 32: instruction memory words; must equal 2**ADDR_W.
- `DATA_W`, 32: instruction and result width.
- `CYC_W`, 16: run-cycle budget width.

Ports:
- `clk`, input, 1: single clock for loader and core.
- `reset`, input, 1: asynchronous, active-low; all state cleared on assertion.
- `start`, input, 1: begin a load; sampled only in IDLE, DONE or ERR.
- `abort`, input, 1: return to IDLE from any state.
- `prog_len`, input, ADDR_W+1: number of program words, valid range 1..DEPTH; latched on start.
- `run_cycles`, input, CYC_W: core run budget in clocks; latched on start.
- `s_valid`, input, 1: host word valid.
- `s_ready`, output, 1: loader accepts a word.
- `s_data`, input, DATA_W: host word.
- `ins_wr`, output, 1: connects to core `write_ins`.
- `ins_addr`, output, ADDR_W: connects to core `ins_address`.
- `ins_data`, output, DATA_W: connects to core `ins`.
- `core_reset`, output, 1: active-high core reset.
- `result_in`, input, DATA_W: core `resultado_out`.
- `result`, output, DATA_W: captured result.
- `busy`, output, 1: high in LOAD, FLUSH and RUN.
- `done`, output, 1: high in DONE.
- `err`, output, 1: high in ERR.

## Operation
- Reset values:
  - state IDLE
  - `core_reset`=1
  - `s_ready`=0, `ins_wr`=0, `ins_addr`=0, `ins_data`=0
  - `result`=0, `busy`=0, `done`=0, `err`=0
- States: IDLE, LOAD, (CHECK), FLUSH, RUN, DONE, ERR.
- `core_reset` is 1 in every state except RUN.
- IDLE/DONE/ERR on `start`:
  - `prog_len` = 0 or > DEPTH: go to ERR.
  - Otherwise: latch `prog_len` and `run_cycles`, clear the word counter, go to LOAD. `done`/`err` drop.
- LOAD:
  - `s_ready`=1.
  - Each handshake (`s_valid` & `s_ready`) registers `ins_wr`=1, `ins_addr`=word index, `ins_data`=`s_data` on the next cycle. Index starts at 0 and increments by 1.
  - `s_valid` low inserts bubbles with no write.
  - The handshake of word `prog_len`-1 moves to FLUSH (or CHECK when configured).
- FLUSH: one cycle. The last registered write lands in memory; `s_ready`=0. Then go to RUN.
- RUN:
  - `core_reset`=0 for exactly max(`run_cycles`,1) clocks, counted by a down-counter.
  - On the final RUN cycle, `result` <= `result_in`, then go to DONE.
- DONE: `result` and `done` held until the next accepted `start`.
- ERR: `err`=1, core never released; `start` leaves ERR as above.
- `abort`:
  - Next state IDLE from any state; `core_reset`=1.
  - `result` is retained.
  - A pending registered write still completes.
  - `abort` wins over a simultaneous `start` or handshake.
- Words presented outside LOAD are not accepted (`s_ready`=0).

## Timing
- Handshake to `ins_wr` pulse: 1 cycle.
- Start to first `s_ready`: 1 cycle.
- Last word handshake to `core_reset` falling: 2 cycles (FLUSH, then RUN entry).
- Full program of N words with no bubbles: N + 1 + max(R,1) cycles from first handshake to DONE entry.
- Releasing `reset` mid-operation is not supported. Asserting `reset` forces the reset values immediately, regardless of state.

## Configuration
- `PROGRAM_LOADER_CKSUM_EN` defined:
  - LOAD also accepts one extra word after the program. This word is not written to memory and moves the FSM to CHECK.
  - CHECK compares the extra word against the running XOR of all program words. Match goes to FLUSH; mismatch goes to ERR.
- Undefined: there is no CHECK state and no extra word; the last program word goes directly to FLUSH.

## Structure
- Package `program_loader_pkg`: state enum `ld_state_t`, `LD_DEPTH`, `LD_ADDR_W`, `LD_CYC_W`.
- One sub-module, `ld_cycle_counter`: a loadable down-counter with a terminal flag, used for the RUN budget.

## Test plan
- Load 3 words 0xE3A00005, 0xE2800003, 0xE0800000 with `run_cycles`=10:
  - Writes land at addresses 0, 1, 2.
  - `core_reset` low for exactly 10 clocks.
  - `result` equals `result_in` sampled on the last RUN cycle.
  - `done`=1.
- `s_valid` toggling every other cycle: addresses stay contiguous, with no duplicate or missing `ins_wr`.
- `prog_len`=0, and separately `prog_len`=33: ERR, `err`=1, `core_reset` stays 1, no `ins_wr`.
- `abort` during word 2 of 4 and again mid-RUN: next state IDLE, `core_reset`=1 next cycle, `result` unchanged. A new `start` reloads from address 0.
- With `PROGRAM_LOADER_CKSUM_EN`, words 0x1, 0x2:
  - Checksum 0x3: run proceeds.
  - Checksum 0x4: ERR, core never released.
- Async reset asserted mid-LOAD: all outputs take reset values without a clock edge.
